tx_frame_sched: RTL and testbench

TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

---
 rtl/tx_frame_sched_if.sv | 49 ++++
 rtl/tx_frame_sched.sv | 198 +++++++++++++++++++
 tb/tb_tx_frame_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_sched_if.sv
// -----------------------------------------------------------------------------
// tx_frame_sched_if
//   Bundles the requester-side byte streams and the output-FIFO write port of
//   the frame scheduler.
//
//   src_data   [NUM_SRC][8]  payload byte offered by each source
//   src_valid  [NUM_SRC]     source i has a byte / requests the FIFO
//   src_last   [NUM_SRC]     byte on src_data[i] ends the frame
//   src_ready  [NUM_SRC]     byte from source i accepted this cycle
//   dout       [8]           byte written to the output FIFO
//   wr_en                    output FIFO write strobe
//   fifo_out_full            output FIFO cannot take a byte
//
//   master : the scheduler (drives src_ready, dout, wr_en)
//   slave  : the environment (sources and FIFO)
// -----------------------------------------------------------------------------
interface tx_frame_sched_if #(
   parameter int unsigned NUM_SRC = 2
);

   logic [NUM_SRC-1:0][7:0] src_data;
   logic [NUM_SRC-1:0]      src_valid;
   logic [NUM_SRC-1:0]      src_last;
   logic [NUM_SRC-1:0]      src_ready;
   logic [7:0]              dout;
   logic                    wr_en;
   logic                    fifo_out_full;

   modport master (
      input  src_data,
      input  src_valid,
      input  src_last,
      input  fifo_out_full,
      output src_ready,
      output dout,
      output wr_en
   );

   modport slave (
      output src_data,
      output src_valid,
      output src_last,
      output fifo_out_full,
      input  src_ready,
      input  dout,
      input  wr_en
   );

endinterface

// File: rtl/tx_frame_sched.sv
// -----------------------------------------------------------------------------
// tx_frame_sched
//   Round-robin scheduler that lets NUM_SRC byte-stream sources share one
//   output FIFO. Each granted source gets a complete frame written:
//      SYNC_BYTE, {6'b0, source id}, payload bytes..., checksum
//   The checksum is the XOR of the id byte and every payload byte. The grant
//   is held for the whole frame; the next arbitration happens in ST_IDLE,
//   searching from the source after the previous winner.
//
//   Parameters
//     NUM_SRC    number of sources (2..4)
//     SYNC_BYTE  first byte of every frame
//
//   Ports
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     bus        tx_frame_sched_if.master (source streams + FIFO write port)
//     busy       high whenever a frame is in progress (not ST_IDLE)
//     grant_id   source owning the FIFO; holds its last value in ST_IDLE
//
//   dout, wr_en and src_ready are combinational from the state and the
//   current inputs, so wr_en drops in the same cycle fifo_out_full rises.
// -----------------------------------------------------------------------------
module tx_frame_sched #(
   parameter int unsigned NUM_SRC   = 2,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   tx_frame_sched_if.master bus,
   output logic             busy,
   output logic [1:0]       grant_id
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_ID,
      ST_PAYLOAD,
      ST_CKSUM
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [1:0] grant_q;
   logic [1:0] grant_d;
   logic [1:0] last_grant_q;
   logic [1:0] last_grant_d;
   logic [7:0] cksum_q;
   logic [7:0] cksum_d;

   // View of the currently granted source
   logic [7:0] sel_data;
   logic       sel_valid;
   logic       sel_last;

   // Round-robin arbitration result
   logic        rr_found;
   logic [1:0]  rr_pick;
   int unsigned rr_dist;
   int unsigned rr_best;

   // Combinational outputs
   logic [7:0]         dout_c;
   logic               wr_en_c;
   logic [NUM_SRC-1:0] src_ready_c;

   // --------------------------------------------------------------------------
   // Round-robin pick: each requester's distance from (last_grant+1) modulo
   // NUM_SRC is computed and the smallest wins. The 2*NUM_SRC bias keeps the
   // subtraction non-negative for every last_grant value.
   // --------------------------------------------------------------------------
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      rr_best  = NUM_SRC;
      rr_dist  = '0;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
         rr_dist = (j + 2 * NUM_SRC - 1 - 32'(last_grant_q)) % NUM_SRC;
         if (bus.src_valid[j] && (rr_dist < rr_best)) begin
            rr_best  = rr_dist;
            rr_pick  = 2'(j);
            rr_found = 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Granted-source mux. Compared against each index rather than indexing with
   // grant_q directly so an out-of-range grant can never select anything.
   // --------------------------------------------------------------------------
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
         if (2'(j) == grant_q) begin
            sel_data  = bus.src_data[j];
            sel_valid = bus.src_valid[j];
            sel_last  = bus.src_last[j];
         end
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cksum_d      = cksum_q;
      dout_c       = 8'h00;
      wr_en_c      = 1'b0;
      src_ready_c  = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (rr_found) begin
               grant_d      = rr_pick;
               last_grant_d = rr_pick;
               cksum_d      = 8'h00;
               state_d      = ST_SYNC;
            end
         end

         // The sync byte is not part of the checksum.
         ST_SYNC: begin
            dout_c  = SYNC_BYTE;
            wr_en_c = ~bus.fifo_out_full;
            if (wr_en_c) begin
               state_d = ST_ID;
            end
         end

         ST_ID: begin
            dout_c  = {6'b0, grant_q};
            wr_en_c = ~bus.fifo_out_full;
            if (wr_en_c) begin
               cksum_d = cksum_q ^ dout_c;
               state_d = ST_PAYLOAD;
            end
         end

         // A granted source with src_valid low simply stalls the frame.
         ST_PAYLOAD: begin
            dout_c  = sel_data;
            wr_en_c = sel_valid & ~bus.fifo_out_full;
            for (int unsigned j = 0; j < NUM_SRC; j++) begin
               src_ready_c[j] = wr_en_c && (2'(j) == grant_q);
            end
            if (wr_en_c) begin
               cksum_d = cksum_q ^ sel_data;
               if (sel_last) begin
                  state_d = ST_CKSUM;
               end
            end
         end

         ST_CKSUM: begin
            dout_c  = cksum_q;
            wr_en_c = ~bus.fifo_out_full;
            if (wr_en_c) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers. last_grant resets to NUM_SRC-1 so source 0 wins the
   // first arbitration after reset.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= 2'(NUM_SRC - 1);
         cksum_q      <= 8'h00;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cksum_q      <= cksum_d;
      end
   end

   assign bus.dout      = dout_c;
   assign bus.wr_en     = wr_en_c;
   assign bus.src_ready = src_ready_c;
   assign busy          = (state_q != ST_IDLE);
   assign grant_id      = grant_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_sched
//   Self-checking bench for tx_frame_sched with NUM_SRC = 4.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_tx_frame_sched;

   localparam int NS = 4;
   localparam int NF = 8;

   logic       clk;
   logic       rst;
   logic       busy;
   logic [1:0] grant_id;

   tx_frame_sched_if #(.NUM_SRC(NS)) bus ();

   tx_frame_sched #(
      .NUM_SRC   (NS),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .grant_id (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [3:0] v;
      logic [3:0] l;
      logic [7:0] d;
      logic       f;
      logic       wr;
      logic [7:0] dout;
      logic [3:0] rdy;
      logic       busy;
      logic [1:0] g;
   } vec_t;

   vec_t tbl [16];

   int vectors;
   int miscompares;

   logic       s_wr;
   logic [7:0] s_dout;
   logic [3:0] s_rdy;
   logic       s_busy;
   logic [1:0] s_grant;

   logic [7:0] got32 [16];
   logic [1:0] gnt32 [16];
   logic [7:0] exp32 [16];
   int         nw;

   // random-test state
   logic [7:0] fb   [NS][NF][5];
   int         flen [NS][NF];
   int         fi   [NS];
   int         pi   [NS];
   logic [3:0] rv;
   logic [3:0] rl;
   logic       rf;
   logic [7:0] eq [$];
   logic       m_idle;
   logic [1:0] m_last;
   logic [1:0] m_grant;
   int         m_pos;
   logic [7:0] m_ck;
   logic       payload;
   logic       exp_wr;
   logic       done;
   int         cyc;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [3:0] v, input logic [3:0] l,
                         input logic [7:0] d0, input logic [7:0] d1, input logic f);
      bus.src_valid     = v;
      bus.src_last      = l;
      bus.src_data[0]   = d0;
      bus.src_data[1]   = d1;
      bus.src_data[2]   = d0;
      bus.src_data[3]   = d0;
      bus.fifo_out_full = f;
   endtask

   task automatic sample();
      @(negedge clk);
      s_wr    = bus.wr_en;
      s_dout  = bus.dout;
      s_rdy   = bus.src_ready;
      s_busy  = busy;
      s_grant = grant_id;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l,
                        input logic [7:0] d0, input logic [7:0] d1, input logic f);
      set_in(v, l, d0, d1, f);
      sample();
      step();
   endtask

   // Reference round-robin: first requester scanning from last+1.
   function automatic logic [1:0] rr_ref(input logic [1:0] last, input logic [3:0] req);
      logic [1:0] r;
      r = last;
      for (int k = NS; k >= 1; k--) begin
         if (req[(int'(last) + k) % NS]) r = 2'((int'(last) + k) % NS);
      end
      return r;
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;

      //              v        l        d     f     wr    dout   rdy      busy  g
      tbl[0]  = '{4'b0001, 4'b0000, 8'h11, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
      tbl[1]  = '{4'b0001, 4'b0000, 8'h11, 1'b0, 1'b1, 8'hA5, 4'b0000, 1'b1, 2'd0};
      tbl[2]  = '{4'b0001, 4'b0000, 8'h11, 1'b0, 1'b1, 8'h00, 4'b0000, 1'b1, 2'd0};
      tbl[3]  = '{4'b0001, 4'b0000, 8'h11, 1'b0, 1'b1, 8'h11, 4'b0001, 1'b1, 2'd0};
      tbl[4]  = '{4'b0001, 4'b0001, 8'h22, 1'b0, 1'b1, 8'h22, 4'b0001, 1'b1, 2'd0};
      tbl[5]  = '{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, 8'h33, 4'b0000, 1'b1, 2'd0};
      tbl[6]  = '{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
      tbl[7]  = '{4'b0010, 4'b0010, 8'h5A, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
      tbl[8]  = '{4'b0010, 4'b0010, 8'h5A, 1'b0, 1'b1, 8'hA5, 4'b0000, 1'b1, 2'd1};
      tbl[9]  = '{4'b0010, 4'b0010, 8'h5A, 1'b1, 1'b0, 8'h01, 4'b0000, 1'b1, 2'd1};
      tbl[10] = '{4'b0010, 4'b0010, 8'h5A, 1'b1, 1'b0, 8'h01, 4'b0000, 1'b1, 2'd1};
      tbl[11] = '{4'b0010, 4'b0010, 8'h5A, 1'b1, 1'b0, 8'h01, 4'b0000, 1'b1, 2'd1};
      tbl[12] = '{4'b0010, 4'b0010, 8'h5A, 1'b0, 1'b1, 8'h01, 4'b0000, 1'b1, 2'd1};
      tbl[13] = '{4'b0010, 4'b0010, 8'h5A, 1'b0, 1'b1, 8'h5A, 4'b0010, 1'b1, 2'd1};
      tbl[14] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, 8'h5B, 4'b0000, 1'b1, 2'd1};
      tbl[15] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};

      exp32 = '{8'hA5, 8'h00, 8'h10, 8'h10, 8'hA5, 8'h01, 8'h20, 8'h21,
                8'hA5, 8'h00, 8'h10, 8'h10, 8'hA5, 8'h01, 8'h20, 8'h21};

      // ---------------- reset state ----------------
      rst = 1'b1;
      set_in(4'b0011, 4'b0000, 8'h00, 8'h00, 1'b0);
      sample();
      chk("rst_wr_en", s_wr, 1'b0);
      chk("rst_dout", s_dout, 8'h00);
      chk("rst_ready", s_rdy, 4'b0000);
      chk("rst_busy", s_busy, 1'b0);
      chk("rst_grant", s_grant, 2'd0);
      step();
      rst = 1'b0;

      // ---------------- table: basic frame and ID-phase backpressure ----------
      for (int i = 0; i < 16; i++) begin
         set_in(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].d, tbl[i].f);
         sample();
         chk($sformatf("tbl%0d_wr_en", i), s_wr, tbl[i].wr);
         chk($sformatf("tbl%0d_dout", i), s_dout, tbl[i].dout);
         chk($sformatf("tbl%0d_ready", i), s_rdy, tbl[i].rdy);
         chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].busy);
         chk($sformatf("tbl%0d_grant", i), s_grant, tbl[i].g);
         step();
      end

      // ---------------- alternating grants, 1-byte frames ----------------
      nw = 0;
      for (int c = 0; c < 40 && nw < 16; c++) begin
         drive(4'b0011, 4'b0011, 8'h10, 8'h20, 1'b0);
         if (s_wr) begin
            got32[nw] = s_dout;
            gnt32[nw] = s_grant;
            nw++;
         end
      end
      chk("alt_write_count", 8'(nw), 8'd16);
      for (int i = 0; i < nw; i++) begin
         chk($sformatf("alt_byte%0d", i), got32[i], exp32[i]);
         if (i % 4 == 0) chk($sformatf("alt_grant%0d", i / 4), gnt32[i], 2'((i / 4) % 2));
      end

      // ---------------- granted source stalls mid-payload ----------------
      drive(4'b0010, 4'b0000, 8'h31, 8'h31, 1'b0);
      chk("stall_idle_busy", s_busy, 1'b0);
      drive(4'b0011, 4'b0000, 8'h31, 8'h31, 1'b0);
      chk("stall_sync_dout", s_dout, 8'hA5);
      chk("stall_sync_grant", s_grant, 2'd1);
      drive(4'b0011, 4'b0000, 8'h31, 8'h31, 1'b0);
      chk("stall_id_dout", s_dout, 8'h01);
      drive(4'b0011, 4'b0000, 8'h31, 8'h31, 1'b0);
      chk("stall_p0_dout", s_dout, 8'h31);
      chk("stall_p0_ready", s_rdy, 4'b0010);
      for (int c = 0; c < 5; c++) begin
         drive(4'b0001, 4'b0000, 8'h32, 8'h32, 1'b0);
         chk($sformatf("stall%0d_wr_en", c), s_wr, 1'b0);
         chk($sformatf("stall%0d_ready", c), s_rdy, 4'b0000);
         chk($sformatf("stall%0d_grant", c), s_grant, 2'd1);
      end
      drive(4'b0011, 4'b0010, 8'h32, 8'h32, 1'b0);
      chk("stall_p1_wr_en", s_wr, 1'b1);
      chk("stall_p1_dout", s_dout, 8'h32);
      chk("stall_p1_ready", s_rdy, 4'b0010);
      drive(4'b0001, 4'b0000, 8'h00, 8'h00, 1'b0);
      chk("stall_cksum_wr_en", s_wr, 1'b1);
      chk("stall_cksum_dout", s_dout, 8'h02);
      chk("stall_cksum_grant", s_grant, 2'd1);
      drive(4'b0001, 4'b0000, 8'h00, 8'h00, 1'b0);
      chk("stall_gap_wr_en", s_wr, 1'b0);
      chk("stall_gap_grant", s_grant, 2'd1);
      drive(4'b0001, 4'b0000, 8'h00, 8'h00, 1'b0);
      chk("next_sync_dout", s_dout, 8'hA5);
      chk("next_sync_grant", s_grant, 2'd0);
      drive(4'b0001, 4'b0000, 8'h44, 8'h44, 1'b0);
      chk("next_id_dout", s_dout, 8'h00);
      drive(4'b0001, 4'b0000, 8'h44, 8'h44, 1'b0);
      chk("next_p0_dout", s_dout, 8'h44);

      // ---------------- asynchronous reset inside the payload ----------------
      set_in(4'b0001, 4'b0001, 8'h55, 8'h55, 1'b0);
      #2;
      chk("pre_rst_wr_en", bus.wr_en, 1'b1);
      rst = 1'b1;
      #1;
      chk("async_rst_wr_en", bus.wr_en, 1'b0);
      chk("async_rst_dout", bus.dout, 8'h00);
      chk("async_rst_ready", bus.src_ready, 4'b0000);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_grant", grant_id, 2'd0);
      step();
      rst = 1'b0;
      drive(4'b0010, 4'b0010, 8'h77, 8'h77, 1'b0);
      chk("post_rst_idle_wr_en", s_wr, 1'b0);
      drive(4'b0010, 4'b0010, 8'h77, 8'h77, 1'b0);
      chk("post_rst_sync_dout", s_dout, 8'hA5);
      chk("post_rst_sync_wr_en", s_wr, 1'b1);
      drive(4'b0010, 4'b0010, 8'h77, 8'h77, 1'b0);
      chk("post_rst_id_dout", s_dout, 8'h01);
      drive(4'b0010, 4'b0010, 8'h77, 8'h77, 1'b0);
      chk("post_rst_p0_dout", s_dout, 8'h77);
      drive(4'b0000, 4'b0000, 8'h00, 8'h00, 1'b0);
      chk("post_rst_cksum_dout", s_dout, 8'h76);
      chk("post_rst_cksum_wr_en", s_wr, 1'b1);
      drive(4'b0000, 4'b0000, 8'h00, 8'h00, 1'b0);
      chk("post_rst_gap_wr_en", s_wr, 1'b0);

      // ---------------- randomized traffic against a frame-level model -------
      for (int s = 0; s < NS; s++) begin
         fi[s] = 0;
         pi[s] = 0;
         for (int f = 0; f < NF; f++) begin
            flen[s][f] = int'($urandom_range(1, 5));
            for (int b = 0; b < 5; b++) fb[s][f][b] = 8'($urandom);
         end
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_idle  = 1'b1;
      m_last  = 2'(NS - 1);
      m_grant = 2'd0;
      m_pos   = 0;
      done    = 1'b0;
      cyc     = 0;
      while (!done && cyc < 8000) begin
         for (int s = 0; s < NS; s++) begin
            if (fi[s] < NF) begin
               rv[s] = ($urandom_range(0, 9) < 7);
               bus.src_data[s] = fb[s][fi[s]][pi[s]];
               rl[s] = (pi[s] == flen[s][fi[s]] - 1);
            end else begin
               rv[s] = 1'b0;
               bus.src_data[s] = 8'($urandom);
               rl[s] = 1'($urandom_range(0, 1));
            end
         end
         rf = ($urandom_range(0, 3) == 0);
         bus.src_valid     = rv;
         bus.src_last      = rl;
         bus.fifo_out_full = rf;
         sample();

         if (rf) chk("rnd_wr_while_full", s_wr, 1'b0);
         chk("rnd_ready_without_wr", s_rdy & ~{4{s_wr}}, 4'b0000);

         if (m_idle) begin
            chk("rnd_idle_busy", s_busy, 1'b0);
            chk("rnd_idle_wr_en", s_wr, 1'b0);
            chk("rnd_idle_dout", s_dout, 8'h00);
            if (rv != 4'b0000) begin
               m_grant = rr_ref(m_last, rv);
               m_last  = m_grant;
               eq.delete();
               eq.push_back(8'hA5);
               eq.push_back({6'b0, m_grant});
               m_ck = {6'b0, m_grant};
               for (int b = 0; b < flen[m_grant][fi[m_grant]]; b++) begin
                  eq.push_back(fb[m_grant][fi[m_grant]][b]);
                  m_ck = m_ck ^ fb[m_grant][fi[m_grant]][b];
               end
               eq.push_back(m_ck);
               m_pos  = 0;
               m_idle = 1'b0;
            end
         end else begin
            chk("rnd_busy", s_busy, 1'b1);
            chk("rnd_grant", s_grant, m_grant);
            payload = (m_pos >= 2) && (m_pos < eq.size() - 1);
            exp_wr  = !rf && (!payload || rv[m_grant]);
            chk("rnd_wr_en", s_wr, exp_wr);
            if (s_wr) begin
               chk($sformatf("rnd_byte%0d", m_pos), s_dout, eq[m_pos]);
               chk("rnd_ready", s_rdy, payload ? 4'(1 << m_grant) : 4'b0000);
               m_pos++;
               if (m_pos == eq.size()) m_idle = 1'b1;
            end else begin
               chk("rnd_ready_idle", s_rdy, 4'b0000);
            end
         end

         for (int s = 0; s < NS; s++) begin
            if (s_rdy[s] && rv[s] && fi[s] < NF) begin
               pi[s]++;
               if (pi[s] == flen[s][fi[s]]) begin
                  pi[s] = 0;
                  fi[s]++;
               end
            end
         end
         done = m_idle && (fi[0] == NF) && (fi[1] == NF) && (fi[2] == NF) && (fi[3] == NF);
         cyc++;
         step();
      end
      chk("rnd_all_frames_done", 8'(done), 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
